// File: rtl/rtype_exec_sequencer_if.sv
// Bus bundle between the R-type sequencer and its environment:
// the instruction valid/ready handshake, the register-bank controls,
// and the ALU steering/result path.
//   slave  : the sequencer side (takes instructions, drives bank/ALU controls)
//   master : the environment side (supplies instructions, bank and ALU)
// Signals:
//   ins_valid/ins/ins_ready       instruction handshake
//   rf_re/rf_we                   register-bank read/write enables
//   rs1_addr/rs2_addr/rd_addr     register indices
//   alu_fun/alu_s_i               ALU function and SUB/SRA select
//   alu_result                    combinational ALU output
//   rd_data                       registered write-back data
//   busy/retire/illegal           status
//   retired_count                 saturating retired-instruction count
interface rtype_exec_sequencer_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             ins_valid;
    logic [31:0]      ins;
    logic             ins_ready;
    logic             rf_re;
    logic             rf_we;
    logic [4:0]       rs1_addr;
    logic [4:0]       rs2_addr;
    logic [4:0]       rd_addr;
    logic [2:0]       alu_fun;
    logic             alu_s_i;
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  rd_data;
    logic             busy;
    logic             retire;
    logic             illegal;
    logic [CNT_W-1:0] retired_count;

    modport slave (
        input  ins_valid, ins, alu_result,
        output ins_ready, rf_re, rf_we, rs1_addr, rs2_addr, rd_addr,
               alu_fun, alu_s_i, rd_data, busy, retire, illegal, retired_count
    );

    modport master (
        output ins_valid, ins, alu_result,
        input  ins_ready, rf_re, rf_we, rs1_addr, rs2_addr, rd_addr,
               alu_fun, alu_s_i, rd_data, busy, retire, illegal, retired_count
    );
endinterface

// File: rtl/rtype_exec_sequencer.sv
// Multi-cycle sequencer for the RV32 R-type datapath (decoder, 32x32
// register bank, ALU). One instruction is accepted per handshake, checked
// for R-type legality, then walked through READ -> EXEC -> WB; illegal
// words take a two-cycle ERR detour that only pulses `illegal`.
// Ports:
//   clk  : clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : rtype_exec_sequencer_if.slave (handshake, bank, ALU, status)
module rtype_exec_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    rtype_exec_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       rs1_q, rs1_d;
    logic [4:0]       rs2_q, rs2_d;
    logic [4:0]       rd_q, rd_d;
    logic [2:0]       fun_q, fun_d;
    logic             s_q, s_d;
    logic [XLEN-1:0]  rd_data_q, rd_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Base R-type: funct7 must be zero, except bit 30 which selects SUB/SRA
    // and is only meaningful for funct3 000 and 101.
    function automatic logic is_legal_rtype(input logic [31:0] w);
        logic op_ok, f7_zero, f7_alt;
        op_ok   = (w[6:0] == 7'b0110011);
        f7_zero = (w[31:25] == 7'b0000000);
        f7_alt  = (w[31:25] == 7'b0100000) &&
                  ((w[14:12] == 3'b000) || (w[14:12] == 3'b101));
        return op_ok && (f7_zero || f7_alt);
    endfunction

    // Counter holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d   = state_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        fun_d     = fun_q;
        s_d       = s_q;
        rd_data_d = rd_data_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ins_valid) begin
                    // Fields are latched even for illegal words; harmless,
                    // and keeps addresses stable until the next IDLE.
                    rs1_d   = bus.ins[19:15];
                    rs2_d   = bus.ins[24:20];
                    rd_d    = bus.ins[11:7];
                    fun_d   = bus.ins[14:12];
                    s_d     = bus.ins[30];
                    state_d = is_legal_rtype(bus.ins) ? S_READ : S_ERR;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                // Bank data arrived this cycle; ALU output has settled.
                rd_data_d = bus.alu_result;
                state_d   = S_WB;
            end
            S_WB: begin
                cnt_d   = sat_inc(cnt_q);
                state_d = S_IDLE;
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            fun_q     <= '0;
            s_q       <= 1'b0;
            rd_data_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            fun_q     <= fun_d;
            s_q       <= s_d;
            rd_data_q <= rd_data_d;
            cnt_q     <= cnt_d;
        end
    end

    // Strobes are gated by rst so a reset landing mid-instruction can never
    // produce a bank write or a stray status pulse in that cycle.
    always_comb begin
        bus.ins_ready     = !rst && (state_q == S_IDLE);
        bus.rf_re         = !rst && (state_q == S_READ);
        bus.rf_we         = !rst && (state_q == S_WB) && (rd_q != 5'd0);
        bus.retire        = !rst && (state_q == S_WB);
        bus.illegal       = !rst && (state_q == S_ERR);
        bus.busy          = !rst && (state_q != S_IDLE);
        bus.rs1_addr      = rs1_q;
        bus.rs2_addr      = rs2_q;
        bus.rd_addr       = rd_q;
        bus.alu_fun       = fun_q;
        bus.alu_s_i       = s_q;
        bus.rd_data       = rd_data_q;
        bus.retired_count = cnt_q;
    end

endmodule

// File: tb/tb_rtype_exec_sequencer.sv
// Directed bench for rtype_exec_sequencer with a small register-bank and
// ALU model around it. The counter is built 4 bits wide here so that
// saturation is reached in a few dozen cycles.
module tb_rtype_exec_sequencer;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rtype_exec_sequencer_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    rtype_exec_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register bank model: synchronous read, bench-side preload port.
    logic [31:0] regs [32];
    logic [31:0] rdat1, rdat2;
    logic        tb_clr, tb_we;
    logic [4:0]  tb_waddr;
    logic [31:0] tb_wdata;

    always @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (bus.rf_we) begin
            regs[bus.rd_addr] <= bus.rd_data;
        end else if (tb_we) begin
            regs[tb_waddr] <= tb_wdata;
        end
        if (bus.rf_re) begin
            rdat1 <= regs[bus.rs1_addr];
            rdat2 <= regs[bus.rs2_addr];
        end
    end

    // ALU model.
    always_comb begin
        bus.alu_result = 32'd0;
        case (bus.alu_fun)
            3'b000: bus.alu_result = bus.alu_s_i ? rdat1 - rdat2 : rdat1 + rdat2;
            3'b001: bus.alu_result = rdat1 << rdat2[4:0];
            3'b010: bus.alu_result = {31'd0, $signed(rdat1) < $signed(rdat2)};
            3'b011: bus.alu_result = {31'd0, rdat1 < rdat2};
            3'b100: bus.alu_result = rdat1 ^ rdat2;
            3'b101: bus.alu_result = bus.alu_s_i ? 32'($signed(rdat1) >>> rdat2[4:0])
                                                 : rdat1 >> rdat2[4:0];
            3'b110: bus.alu_result = rdat1 | rdat2;
            default: bus.alu_result = rdat1 & rdat2;
        endcase
    end

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;
    logic [CNT_W-1:0] exp_cnt;

    always @(negedge clk) if (bus.rf_re && bus.rf_we) overlap++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of N+4.
    task automatic run_ins(input string tag, input logic [31:0] w,
                           input logic [4:0] rd, input logic [31:0] data);
        bus.ins_valid = 1'b1; bus.ins = w;
        @(negedge clk);                                   // N+1 READ
        chk({tag, "/re"},    32'(bus.rf_re), 32'd1);
        chk({tag, "/rdy0"},  32'(bus.ins_ready), 32'd0);
        chk({tag, "/busy"},  32'(bus.busy), 32'd1);
        bus.ins_valid = 1'b0; bus.ins = 32'hFFFF_FFFF;
        @(negedge clk);                                   // N+2 EXEC
        chk({tag, "/re_off"}, 32'({bus.rf_re, bus.rf_we}), 32'd0);
        @(negedge clk);                                   // N+3 WB
        chk({tag, "/we"},     32'(bus.rf_we), 32'(rd != 5'd0));
        chk({tag, "/retire"}, 32'(bus.retire), 32'd1);
        chk({tag, "/rd"},     32'(bus.rd_addr), 32'(rd));
        chk({tag, "/data"},   bus.rd_data, data);
        @(negedge clk);                                   // N+4 IDLE
        if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        chk({tag, "/rdy1"},  32'(bus.ins_ready), 32'd1);
        chk({tag, "/cnt"},   32'(bus.retired_count), 32'(exp_cnt));
    endtask

    task automatic run_bad(input string tag, input logic [31:0] w);
        bus.ins_valid = 1'b1; bus.ins = w;
        @(negedge clk);                                   // N+1 ERR
        chk({tag, "/illegal"}, 32'(bus.illegal), 32'd1);
        chk({tag, "/no_rw"},   32'({bus.rf_re, bus.rf_we}), 32'd0);
        chk({tag, "/rdy0"},    32'(bus.ins_ready), 32'd0);
        bus.ins_valid = 1'b0;
        @(negedge clk);                                   // N+2 IDLE
        chk({tag, "/rdy1"},    32'(bus.ins_ready), 32'd1);
        chk({tag, "/ill_off"}, 32'(bus.illegal), 32'd0);
        chk({tag, "/cnt"},     32'(bus.retired_count), 32'(exp_cnt));
    endtask

    logic [31:0] b2b_ins  [3] = '{32'h0020_8333, 32'h0020_D3B3, 32'h0020_A433};
    logic [4:0]  b2b_rd   [3] = '{5'd6, 5'd7, 5'd8};
    logic [31:0] b2b_data [3] = '{32'h8000_0004, 32'h0800_0000, 32'h0000_0001};

    initial begin
        rst = 1'b1; tb_clr = 1'b1; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        bus.ins_valid = 1'b0; bus.ins = 32'd0; exp_cnt = '0;
        repeat (3) @(negedge clk);
        chk("rst/ready", 32'(bus.ins_ready), 32'd0);
        chk("rst/strobes", 32'({bus.rf_re, bus.rf_we, bus.retire, bus.illegal, bus.busy}), 32'd0);
        rst = 1'b0; tb_clr = 1'b0;
        #1;
        chk("rst/ready_up", 32'(bus.ins_ready), 32'd1);
        chk("rst/fields", 32'({bus.rs1_addr, bus.rs2_addr, bus.rd_addr, bus.alu_fun, bus.alu_s_i}), 32'd0);
        chk("rst/rd_data", bus.rd_data, 32'd0);
        chk("rst/cnt", 32'(bus.retired_count), 32'd0);
        @(negedge clk);

        // ADD, SUB, then SRA on a negative operand.
        preload(5'd1, 32'd5);
        preload(5'd2, 32'd3);
        run_ins("add", 32'h0020_81B3, 5'd3, 32'd8);
        chk("add/x3", regs[3], 32'd8);
        run_ins("sub", 32'h4020_8233, 5'd4, 32'd2);
        preload(5'd1, 32'h8000_0000);
        preload(5'd2, 32'd4);
        run_ins("sra", 32'h4020_D2B3, 5'd5, 32'hF800_0000);

        // Illegal words: ADDI, SLL with bit 30, MUL.
        run_bad("addi", 32'h0000_0013);
        run_bad("sll30", 32'h4020_9033);
        run_bad("mul", 32'h0220_8133);

        // Destination x0: retires and counts, no write.
        run_ins("x0", 32'h0020_8033, 5'd0, 32'h8000_0004);
        chk("x0/reg", regs[0], 32'd0);

        // Back-to-back with ins_valid held high; distractor word while busy.
        bus.ins_valid = 1'b1; bus.ins = b2b_ins[0];
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            chk($sformatf("b2b/rdy%0d", c), 32'(bus.ins_ready), 32'(c % 4 == 0));
            if (c % 4 != 0)
                chk($sformatf("b2b/rd%0d", c), 32'(bus.rd_addr), 32'(b2b_rd[(c - 1) / 4]));
            if (c % 4 == 1) bus.ins = 32'h0020_84B3;
            if (c % 4 == 3) begin
                chk($sformatf("b2b/data%0d", c), bus.rd_data, b2b_data[(c - 1) / 4]);
                if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
                if (c == 11) bus.ins_valid = 1'b0;
            end
            if (c % 4 == 0 && c < 12) bus.ins = b2b_ins[c / 4];
        end
        chk("b2b/cnt", 32'(bus.retired_count), 32'(exp_cnt));
        chk("b2b/x9", regs[9], 32'd0);

        // Reset landing in WB.
        bus.ins_valid = 1'b1; bus.ins = 32'h0020_8533;
        @(negedge clk); bus.ins_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwb/in_wb", 32'(bus.retire), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwb/we", 32'(bus.rf_we), 32'd0);
        chk("rstwb/retire", 32'(bus.retire), 32'd0);
        @(negedge clk);
        chk("rstwb/busy", 32'(bus.busy), 32'd0);
        chk("rstwb/rd_data", bus.rd_data, 32'd0);
        chk("rstwb/cnt", 32'(bus.retired_count), 32'd0);
        chk("rstwb/rd", 32'(bus.rd_addr), 32'd0);
        rst = 1'b0; exp_cnt = '0;
        #1;
        chk("rstwb/ready", 32'(bus.ins_ready), 32'd1);
        chk("rstwb/x10", regs[10], 32'd0);
        @(negedge clk);

        // Drive the counter to all-ones and one past it.
        for (int k = 0; k < 16; k++)
            run_ins($sformatf("sat%0d", k), 32'h0020_81B3, 5'd3, 32'h8000_0004);
        chk("sat/hold", 32'(bus.retired_count), 32'hF);

        chk("no_overlap", 32'(overlap), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
